video_timing_gen: RTL and testbench

//  - Raster timing generator on the pixel clock (25.2 MHz output of hdmi_pll) for the HDMI path.
//  - Produces hsync, vsync, data-enable and the active pixel coordinates, all aligned to each other.
//  - These feed the pattern source and the TMDS encoders downstream. Defaults give 640x480@60.

---
 rtl/video_timing_pkg.sv | 30 +++
 rtl/video_timing_if.sv | 22 ++
 rtl/video_axis_counter.sv | 46 ++++
 rtl/video_timing_gen.sv | 109 ++++++++++
 tb/tb_video_timing_gen.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants for the HDMI raster timing generator: standard mode sets
// and the counter-width helper used to size the h/v position counters.
package video_timing_pkg;

  // 640x480@60 (25.2 MHz pixel clock)
  localparam int M640_H_ACTIVE = 640;
  localparam int M640_H_FP     = 16;
  localparam int M640_H_SYNC   = 96;
  localparam int M640_H_BP     = 48;
  localparam int M640_V_ACTIVE = 480;
  localparam int M640_V_FP     = 10;
  localparam int M640_V_SYNC   = 2;
  localparam int M640_V_BP     = 33;

  // 720x480@60 (27 MHz pixel clock)
  localparam int M720_H_ACTIVE = 720;
  localparam int M720_H_FP     = 16;
  localparam int M720_H_SYNC   = 62;
  localparam int M720_H_BP     = 60;
  localparam int M720_V_ACTIVE = 480;
  localparam int M720_V_FP     = 9;
  localparam int M720_V_SYNC   = 6;
  localparam int M720_V_BP     = 30;

  // Bits needed to hold a counter running 0..total-1 (never less than 1).
  function automatic int cnt_width(input int total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle handed from the timing generator to the pattern
// source and TMDS encoders. x/y are valid only where de is high.
interface video_timing_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    output hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    input hsync, vsync, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/video_axis_counter.sv
// One raster axis: a position counter 0..TOTAL-1 that advances on step,
// plus the combinational decode of the current position (terminal count,
// active region, sync region).
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int W     = cnt_width(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync_act
);

  // A zero-length region would collapse the compare bounds below.
  if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0) begin : g_bad_timing
    $error("video_axis_counter: ACTIVE, FP, SYNC and BP must all be non-zero");
  end

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  assign wrap     = (cnt == LAST);
  assign active   = (cnt < ACT_END);
  assign sync_act = (cnt >= SYNC_LO) && (cnt < SYNC_HI);

  // Position counter: advance on step, wrap from the last position to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator on the pixel clock. Two axis counters track the
// raster position; every output is the registered decode of that position,
// so hsync/vsync/de/x/y/pulses leave this block mutually aligned.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = M640_H_ACTIVE,
  parameter int H_FP     = M640_H_FP,
  parameter int H_SYNC   = M640_H_SYNC,
  parameter int H_BP     = M640_H_BP,
  parameter int V_ACTIVE = M640_V_ACTIVE,
  parameter int V_FP     = M640_V_FP,
  parameter int V_SYNC   = M640_V_SYNC,
  parameter int V_BP     = M640_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  localparam int XW      = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int YW      = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  video_timing_if.master  vid
);

  logic [XW-1:0] h_cnt_p0;
  logic          h_wrap_p0;
  logic          h_act_p0;
  logic          h_sync_p0;
  logic [YW-1:0] v_cnt_p0;
  logic          v_act_p0;
  logic          v_sync_p0;
  // The vertical terminal count is implied by the counter itself; both axes
  // wrap together at the last pixel of the last line.
  logic          v_wrap_unused;
  logic          vld_p0;

  logic          hsync_p1;
  logic          vsync_p1;
  logic          de_p1;
  logic [XW-1:0] x_p1;
  logic [YW-1:0] y_p1;
  logic          ls_p1;
  logic          fs_p1;

  assign vld_p0 = en;

  video_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (vld_p0),
    .cnt      (h_cnt_p0),
    .wrap     (h_wrap_p0),
    .active   (h_act_p0),
    .sync_act (h_sync_p0)
  );

  // vsync therefore only moves at a line boundary.
  video_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (vld_p0 && h_wrap_p0),
    .cnt      (v_cnt_p0),
    .wrap     (v_wrap_unused),
    .active   (v_act_p0),
    .sync_act (v_sync_p0)
  );

  // ---- stage p0 -> p1: register the decode of the current position ----
  // Reset aborts the frame outright; en low freezes every output, pulses included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_p1 <= ~H_POL;
      vsync_p1 <= ~V_POL;
      de_p1    <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      ls_p1    <= 1'b0;
      fs_p1    <= 1'b0;
    end else if (vld_p0) begin
      hsync_p1 <= h_sync_p0 ? H_POL : ~H_POL;
      vsync_p1 <= v_sync_p0 ? V_POL : ~V_POL;
      de_p1    <= h_act_p0 && v_act_p0;
      x_p1     <= h_cnt_p0;
      y_p1     <= v_cnt_p0;
      ls_p1    <= (h_cnt_p0 == '0);
      fs_p1    <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
    end
  end

  assign vid.hsync       = hsync_p1;
  assign vid.vsync       = vsync_p1;
  assign vid.de          = de_p1;
  assign vid.x           = x_p1;
  assign vid.y           = y_p1;
  assign vid.line_start  = ls_p1;
  assign vid.frame_start = fs_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster (34x17 total) so several
// whole frames fit in a short run. A reference model of the raster pushes
// the expected output word per clock; the DUT word is captured alongside and
// each scenario pops and compares both, plus scenario-specific checks.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 4, HS = 8, HB = 6;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 34
  localparam int VT = VA + VF + VS + VB;   // 17
  localparam int FT = HT * VT;             // 578
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b0;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          ls;
    logic          fs;
  } obs_t;

  logic clk;
  logic rst_n;
  logic en;

  video_timing_if #(.XW(XW), .YW(YW)) vif ();

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_POL    (HPOL), .V_POL (VPOL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .vid   (vif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  obs_t obs_q[$];
  obs_t mexp;
  int   mh, mv;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  function automatic obs_t rst_val();
    obs_t r;
    r.hs = ~HPOL; r.vs = ~VPOL; r.de = 1'b0;
    r.x = '0; r.y = '0; r.ls = 1'b0; r.fs = 1'b0;
    return r;
  endfunction

  function automatic obs_t decode(input int h, input int v);
    obs_t d;
    d.de = (h < HA) && (v < VA);
    d.hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
    d.vs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
    d.x  = XW'(h);
    d.y  = YW'(v);
    d.ls = (h == 0);
    d.fs = (h == 0) && (v == 0);
    return d;
  endfunction

  // One clock: drive inputs, advance the model, queue expected and observed words.
  task automatic tick(input logic e, input logic r);
    obs_t o;
    en = e;
    rst_n = r;
    @(posedge clk);
    if (!r) begin
      mh = 0; mv = 0; mexp = rst_val();
    end else if (e) begin
      mexp = decode(mh, mv);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    exp_q.push_back(mexp);
    #1;
    o.hs = vif.hsync; o.vs = vif.vsync; o.de = vif.de;
    o.x = vif.x; o.y = vif.y; o.ls = vif.line_start; o.fs = vif.frame_start;
    obs_q.push_back(o);
    cyc++;
  endtask

  task automatic test_reset();
    obs_t e, o;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
      n_cmp++;
      if (o.de !== 1'b0 || o.hs !== 1'b1 || o.vs !== 1'b1) begin
        n_bad++; $display("FAIL reset_state de/hs/vs got=%b%b%b exp=011", o.de, o.hs, o.vs);
      end
    end
    tick(1'b1, 1'b1);
    e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL release_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
    n_cmp++;
    if (o.de !== 1'b1 || o.x !== '0 || o.y !== '0 || o.fs !== 1'b1 || o.ls !== 1'b1) begin
      n_bad++;
      $display("FAIL first_after_reset de=%b x=%0d y=%0d fs=%b ls=%b exp de=1 x=0 y=0 fs=1 ls=1",
               o.de, o.x, o.y, o.fs, o.ls);
    end
  endtask

  task automatic test_line();
    obs_t e, o;
    int de_n = 0, hs_n = 0, last_ls = -1, ls_n = 0;
    tick(1'b1, 1'b0);
    e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL line_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
    for (int i = 0; i < 2 * HT; i++) begin
      tick(1'b1, 1'b1);
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL line_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o.y === '0) begin
        if (o.de === 1'b1) begin
          de_n++;
          n_cmp++;
          if (o.x >= HA) begin n_bad++; $display("FAIL line_de_x x=%0d exp <%0d", o.x, HA); end
        end
        if (o.hs === 1'b0) begin
          hs_n++;
          n_cmp++;
          if (o.x < HA + HF || o.x >= HA + HF + HS) begin
            n_bad++; $display("FAIL line_hs_x x=%0d exp %0d..%0d", o.x, HA + HF, HA + HF + HS - 1);
          end
        end
      end
      if (o.ls === 1'b1) begin
        ls_n++;
        if (last_ls >= 0) begin
          n_cmp++;
          if (cyc - last_ls != HT) begin
            n_bad++; $display("FAIL line_ls_period got=%0d exp=%0d", cyc - last_ls, HT);
          end
        end
        last_ls = cyc;
      end
    end
    n_cmp++;
    if (de_n != HA) begin n_bad++; $display("FAIL line_de_count got=%0d exp=%0d", de_n, HA); end
    n_cmp++;
    if (hs_n != HS) begin n_bad++; $display("FAIL line_hs_count got=%0d exp=%0d", hs_n, HS); end
    n_cmp++;
    if (ls_n != 2) begin n_bad++; $display("FAIL line_ls_count got=%0d exp=2", ls_n); end
  endtask

  task automatic test_frame();
    obs_t e, o;
    int last_fs = -1, fs_n = 0, de_n = 0, vs_n = 0;
    logic prev_vs = 1'b1;
    tick(1'b1, 1'b0);
    e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL frame_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
    for (int i = 0; i < 2 * FT + 1; i++) begin
      tick(1'b1, 1'b1);
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL frame_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o.fs === 1'b1) begin
        fs_n++;
        if (last_fs >= 0) begin
          n_cmp++;
          if (cyc - last_fs != FT) begin
            n_bad++; $display("FAIL frame_fs_period got=%0d exp=%0d", cyc - last_fs, FT);
          end
          n_cmp++;
          if (de_n != HA * VA) begin n_bad++; $display("FAIL frame_de_count got=%0d exp=%0d", de_n, HA * VA); end
          n_cmp++;
          if (vs_n != VS * HT) begin n_bad++; $display("FAIL frame_vs_count got=%0d exp=%0d", vs_n, VS * HT); end
        end
        last_fs = cyc; de_n = 0; vs_n = 0;
      end
      if (o.de === 1'b1) de_n++;
      if (o.vs === 1'b0) begin
        vs_n++;
        n_cmp++;
        if (o.y < VA + VF || o.y >= VA + VF + VS) begin
          n_bad++; $display("FAIL frame_vs_y y=%0d exp %0d..%0d", o.y, VA + VF, VA + VF + VS - 1);
        end
      end
      if (o.vs !== prev_vs) begin
        n_cmp++;
        if (o.ls !== 1'b1 || o.x !== '0) begin
          n_bad++; $display("FAIL frame_vs_edge ls=%b x=%0d exp ls=1 x=0", o.ls, o.x);
        end
      end
      prev_vs = o.vs;
    end
    n_cmp++;
    if (fs_n != 3) begin n_bad++; $display("FAIL frame_fs_count got=%0d exp=3", fs_n); end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    bit found = 1'b0;
    for (int i = 0; i < FT + 2 && !found; i++) begin
      tick(1'b1, 1'b1);
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wrap_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o.x == HT - 1 && o.y == VT - 1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL wrap_reach got=not_seen exp=x%0d_y%0d", HT - 1, VT - 1); end
    tick(1'b1, 1'b1);
    e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL wrap_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
    n_cmp++;
    if (o.x !== '0 || o.y !== '0 || o.fs !== 1'b1 || o.ls !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_corner x=%0d y=%0d fs=%b ls=%b exp x=0 y=0 fs=1 ls=1", o.x, o.y, o.fs, o.ls);
    end
  endtask

  task automatic test_freeze();
    obs_t e, o, held;
    bit found = 1'b0;
    held = '0;
    for (int i = 0; i < FT + 2 && !found; i++) begin
      tick(1'b1, 1'b1);
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL freeze_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o.x == 10 && o.y == 5) begin found = 1'b1; held = o; end
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL freeze_reach got=not_seen exp=x10_y5"); end
    for (int i = 0; i < 37; i++) begin
      tick(1'b0, 1'b1);
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL freeze_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
      n_cmp++;
      if (o !== held) begin n_bad++; $display("FAIL freeze_hold got=%h exp=%h", o, held); end
    end
    tick(1'b1, 1'b1);
    e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL freeze_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
    n_cmp++;
    if (o.x !== XW'(11) || o.y !== YW'(5)) begin
      n_bad++; $display("FAIL freeze_resume x=%0d y=%0d exp x=11 y=5", o.x, o.y);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    bit found = 1'b0;
    int de_n, hs_n, fs_n;
    for (int i = 0; i < FT + 2 && !found; i++) begin
      tick(1'b1, 1'b1);
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL midrst_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o.x == 30 && o.y == VA + VF) found = 1'b1;
    end
    n_cmp++;
    if (!found || o.vs !== 1'b0) begin
      n_bad++; $display("FAIL midrst_reach found=%0d vs=%b exp found=1 vs=0", found, o.vs);
    end
    tick(1'b1, 1'b0);
    e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL midrst_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
    n_cmp++;
    if (o.vs !== 1'b1 || o.hs !== 1'b1 || o.de !== 1'b0 || o.x !== '0 || o.y !== '0 ||
        o.ls !== 1'b0 || o.fs !== 1'b0) begin
      n_bad++; $display("FAIL midrst_state got=%h exp=%h", o, rst_val());
    end
    tick(1'b1, 1'b1);
    e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL midrst_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
    n_cmp++;
    if (o.x !== '0 || o.y !== '0 || o.de !== 1'b1 || o.fs !== 1'b1) begin
      n_bad++; $display("FAIL midrst_restart x=%0d y=%0d de=%b fs=%b exp 0 0 1 1", o.x, o.y, o.de, o.fs);
    end
    de_n = 1; hs_n = 0; fs_n = 0;
    for (int i = 0; i < HT - 1; i++) begin
      tick(1'b1, 1'b1);
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL midrst_sb cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o.de === 1'b1) de_n++;
      if (o.hs === 1'b0) hs_n++;
      if (o.fs === 1'b1) fs_n++;
    end
    n_cmp++;
    if (de_n != HA || hs_n != HS || fs_n != 0) begin
      n_bad++;
      $display("FAIL midrst_line de=%0d hs=%0d fs=%0d exp de=%0d hs=%0d fs=0", de_n, hs_n, fs_n, HA, HS);
    end
  endtask

  initial begin
    en = 1'b0;
    rst_n = 1'b0;
    mh = 0;
    mv = 0;
    mexp = rst_val();
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_freeze();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
